// File: rtl/seq_divider_ctrl_pkg.sv
// seq_divider_ctrl_pkg: shared ALU constants for the sequential divider.
// Holds the FSM state encoding used by seq_divider_ctrl and the DIV opcode
// that the ALU top-level decoder compares against.
package seq_divider_ctrl_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;
  localparam logic [3:0] OP_DIV  = 4'd9;
  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } div_state_e;
endpackage

// File: rtl/seq_divider_ctrl_sub_stage.sv
// div_sub_stage: (WIDTH+1)-bit subtractor with borrow out for the restoring divider.
// Ports:
//   a_i      minuend (shifted partial remainder)
//   b_i      subtrahend (zero-extended divisor)
//   diff_o   a_i - b_i modulo 2^(WIDTH+1)
//   borrow_o 1 when a_i < b_i
module div_sub_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  output logic [WIDTH:0] diff_o,
  output logic           borrow_o
);
  logic [WIDTH+1:0] sum;
  // Adder form a + ~b + 1: carry out of the top bit means no borrow.
  assign sum      = {1'b0, a_i} + {1'b0, ~b_i} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign diff_o   = sum[WIDTH:0];
  assign borrow_o = ~sum[WIDTH+1];
endmodule

// File: rtl/seq_divider_ctrl.sv
// seq_divider_ctrl: multi-cycle unsigned restoring divider controller.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              request a division, sampled only in IDLE
//   dividend, divisor  operands, sampled with an accepted start
//   busy               high while iterating
//   done               one-cycle pulse, results valid
//   quotient/remainder results, held until the next op's completion
//   div_by_zero        set with the results when divisor was zero
module seq_divider_ctrl
  import seq_divider_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  div_state_e       state_q;
  logic [WIDTH-1:0] q_q, d_q, quo_q, rem_q;
  logic [WIDTH:0]   r_q, shifted, trial, r_d;
  logic [WIDTH-1:0] q_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dbz_q, borrow;
  logic             unused_r_msb;
  // The restored remainder is always below the divisor, so its top bit never
  // feeds the next trial; it is kept only to match the datapath width.
  assign unused_r_msb = r_q[WIDTH];
  assign shifted      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, d_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );
  always_comb begin
    r_d = borrow ? shifted : trial;
    q_d = {q_q[WIDTH-2:0], ~borrow};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            q_q   <= dividend;
            d_q   <= divisor;
            r_q   <= '0;
            cnt_q <= '0;
            // Zero divisor skips iteration; results are loaded on this edge.
            if (divisor == '0) begin
              state_q <= S_FIN;
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            quo_q   <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            dbz_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider_ctrl.sv
// tb_seq_divider_ctrl: table-driven and scoreboard bench for seq_divider_ctrl.
module tb_seq_divider_ctrl;
  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] eq;
    logic [7:0] er;
    logic       ez;
  } vec_t;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         due;
  } exp_t;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       start = 0;
  logic [7:0] dividend = 0;
  logic [7:0] divisor = 0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         n_done = 0;
  exp_t       sb[$];
  exp_t       mon_e;
  vec_t       vecs[16];
  seq_divider_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic push_exp(input logic [7:0] dd, input logic [7:0] dv, input int due);
    exp_t e;
    e.q   = (dv == 0) ? 8'hFF : dd / dv;
    e.r   = (dv == 0) ? dd : dd % dv;
    e.z   = (dv == 0);
    e.due = due;
    sb.push_back(e);
  endtask
  // Scoreboard check: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (sb.size() == 0) chk("stray_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.z);
        chk("latency", cyc, mon_e.due);
      end
    end
  end
  task automatic run_op(input vec_t v);
    int nb = 0;
    bit fin = 0;
    @(negedge clk);
    dividend = v.dd;
    divisor  = v.dv;
    start    = 1;
    sb.push_back('{v.eq, v.er, v.ez, cyc + ((v.dv == 0) ? 2 : 10)});
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        start    = 0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
      end
      if (busy) nb++;
      if (sb.size() == 0) begin
        fin = 1;
        break;
      end
    end
    chk("completed", fin, 1);
    if (!fin) sb.delete();
    chk("busy_cycles", nb, (v.dv == 0) ? 0 : 8);
    chk("hold_quotient", quotient, v.eq);
    chk("hold_remainder", remainder, v.er);
    chk("hold_dbz", div_by_zero, v.ez);
  endtask
  initial begin
    int n0;
    vec_t v;
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
    vecs[3] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0};
    vecs[4] = '{8'd42,  8'd0,   8'hFF,  8'd42, 1'b1};
    vecs[5] = '{8'd9,   8'd3,   8'd3,   8'd0,  1'b0};
    vecs[6] = '{8'd0,   8'd5,   8'd0,   8'd0,  1'b0};
    vecs[7] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
    vecs[8] = '{8'd128, 8'd3,   8'd42,  8'd2,  1'b0};
    vecs[9] = '{8'd1,   8'd255, 8'd0,   8'd1,  1'b0};
    for (int i = 10; i < 16; i++) begin
      vecs[i].dd = 8'($urandom);
      vecs[i].dv = (i == 12) ? 8'd0 : 8'($urandom);
      vecs[i].eq = (vecs[i].dv == 0) ? 8'hFF : vecs[i].dd / vecs[i].dv;
      vecs[i].er = (vecs[i].dv == 0) ? vecs[i].dd : vecs[i].dd % vecs[i].dv;
      vecs[i].ez = (vecs[i].dv == 0);
    end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) run_op(vecs[i]);
    // start pulse with other operands while busy must be ignored
    n0 = n_done;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1;
    push_exp(8'd100, 8'd7, cyc + 10);
    @(negedge clk);
    start = 0;
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1;
    @(negedge clk);
    start = 0;
    repeat (15) @(negedge clk);
    chk("ignore_one_done", n_done - n0, 1);
    chk("ignore_sb_empty", sb.size(), 0);
    // reset in the middle of an operation aborts it without a done pulse
    n0 = n_done;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1;
    repeat (4) @(posedge clk);
    #1;
    start = 0;
    rst_n = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", n_done - n0, 0);
    v = '{8'd81, 8'd9, 8'd9, 8'd0, 1'b0};
    run_op(v);
    // start held high: one accepted op every WIDTH+2 cycles
    n0 = n_done;
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 8'd10;
    start    = 1;
    push_exp(8'd77, 8'd10, cyc + 10);
    push_exp(8'd77, 8'd10, cyc + 20);
    push_exp(8'd77, 8'd10, cyc + 30);
    repeat (30) @(negedge clk);
    start = 0;
    repeat (12) @(negedge clk);
    chk("stream_dones", n_done - n0, 3);
    chk("stream_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
